// File: rtl/adder_loa_acc.sv
// Multi-lane accumulator built on a lower-part-OR approximate adder (LOA) with a
// run-time selectable approximation depth, optional saturation and a valid pipeline.
module adder_loa_acc #(
  parameter int N_LANES    = 4,
  parameter int IP_W       = 16,
  parameter int OC_W       = 24,
  parameter int MAX_APPROX = 8,
  parameter int SATURATE   = 0
) (
  input  logic                              i_clk,
  input  logic                              i_rstn,
  input  logic                              i_cfg_we,
  input  logic [$clog2(MAX_APPROX+1)-1:0]   i_approx_bits,
  input  logic                              i_valid,
  input  logic                              i_clear,
  input  logic [N_LANES-1:0]                i_lane_en,
  input  logic [N_LANES*IP_W-1:0]           i_p,
  output logic [N_LANES*OC_W-1:0]           o_acc,
  output logic                              o_valid,
  output logic [N_LANES-1:0]                o_sat,
  output logic [$clog2(MAX_APPROX+1)-1:0]   o_approx_bits
);

  localparam int AW = $clog2(MAX_APPROX+1);

  logic signed [OC_W-1:0] acc_q [N_LANES];
  logic signed [OC_W-1:0] acc_d [N_LANES];
  logic [N_LANES-1:0]     sat_q, sat_d;
  logic                   vld_q;
  logic [AW-1:0]          k_q, k_d;

  logic signed [IP_W-1:0] p_lane;
  logic signed [OC_W-1:0] p_ext, c_op, sum;
  logic                   ovf;

  // Low k bits are OR-ed; the carry into the exact upper part comes from bit k-1 only.
  function automatic logic signed [OC_W-1:0] loa_add(input logic signed [OC_W-1:0] p,
                                                    input logic signed [OC_W-1:0] c,
                                                    input logic [AW-1:0]          k);
    logic [OC_W-1:0] hi_mask, lo_bits, hi_bits, pc_sh, cy;
    hi_mask = {OC_W{1'b1}} << k;
    lo_bits = (p | c) & ~hi_mask;
    pc_sh   = (p & c) >> (k - AW'(1));
    cy      = '0;
    if (k != '0) cy[0] = pc_sh[0];
    hi_bits = (p & hi_mask) + (c & hi_mask) + (cy << k);
    return hi_bits | lo_bits;
  endfunction

  function automatic logic ovf_fn(input logic signed [OC_W-1:0] p,
                                  input logic signed [OC_W-1:0] c,
                                  input logic signed [OC_W-1:0] r);
    return (p[OC_W-1] == c[OC_W-1]) && (r[OC_W-1] != p[OC_W-1]);
  endfunction

  function automatic logic signed [OC_W-1:0] sat_fn(input logic neg);
    return neg ? {1'b1, {(OC_W-1){1'b0}}} : {1'b0, {(OC_W-1){1'b1}}};
  endfunction

  always_comb begin
    k_d = k_q;
    if (i_cfg_we)
      k_d = (i_approx_bits > AW'(MAX_APPROX)) ? AW'(MAX_APPROX) : i_approx_bits;
  end

  always_comb begin
    p_lane = '0;
    p_ext  = '0;
    c_op   = '0;
    sum    = '0;
    ovf    = 1'b0;
    sat_d  = sat_q;
    for (int n = 0; n < N_LANES; n++) begin
      acc_d[n] = acc_q[n];
      p_lane   = i_p[n*IP_W +: IP_W];
      p_ext    = OC_W'(p_lane);
      c_op     = i_clear ? '0 : acc_q[n];
      sum      = loa_add(p_ext, c_op, k_q);
      ovf      = (SATURATE != 0) && ovf_fn(p_ext, c_op, sum);
      if (ovf) sum = sat_fn(p_ext[OC_W-1]);
      // A cleared lane drops its sticky flag unless this very operation overflows.
      if (i_valid && i_lane_en[n]) begin
        acc_d[n] = sum;
        sat_d[n] = (!i_clear && sat_q[n]) || ovf;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int n = 0; n < N_LANES; n++) acc_q[n] <= '0;
      sat_q <= '0;
      vld_q <= 1'b0;
      k_q   <= '0;
    end else begin
      for (int n = 0; n < N_LANES; n++) acc_q[n] <= acc_d[n];
      sat_q <= sat_d;
      vld_q <= i_valid;
      k_q   <= k_d;
    end
  end

  always_comb begin
    o_acc = '0;
    for (int n = 0; n < N_LANES; n++) o_acc[n*OC_W +: OC_W] = acc_q[n];
  end

  assign o_valid       = vld_q;
  assign o_sat         = sat_q;
  assign o_approx_bits = k_q;

endmodule

// File: tb/tb_adder_loa_acc.sv
// Bench for adder_loa_acc: a saturating and a wrapping instance share stimulus and are
// checked against an arithmetic reference model, a directed vector table and corner sequences.
module tb_adder_loa_acc;
  localparam int NL = 4, IW = 8, OW = 16, MA = 6, AW = 3;

  logic clk = 1'b0;
  logic rstn;
  logic cfg_we, valid, clr;
  logic [AW-1:0] ab;
  logic [NL-1:0] en;
  logic [NL*IW-1:0] p;
  logic [NL*OW-1:0] acc_s, acc_w;
  logic vld_s, vld_w;
  logic [NL-1:0] sat_s, sat_w;
  logic [AW-1:0] ab_s, ab_w;

  always #5 clk = ~clk;

  adder_loa_acc #(.N_LANES(NL), .IP_W(IW), .OC_W(OW), .MAX_APPROX(MA), .SATURATE(1)) u_sat (
    .i_clk(clk), .i_rstn(rstn), .i_cfg_we(cfg_we), .i_approx_bits(ab), .i_valid(valid),
    .i_clear(clr), .i_lane_en(en), .i_p(p), .o_acc(acc_s), .o_valid(vld_s), .o_sat(sat_s),
    .o_approx_bits(ab_s));

  adder_loa_acc #(.N_LANES(NL), .IP_W(IW), .OC_W(OW), .MAX_APPROX(MA), .SATURATE(0)) u_wrap (
    .i_clk(clk), .i_rstn(rstn), .i_cfg_we(cfg_we), .i_approx_bits(ab), .i_valid(valid),
    .i_clear(clr), .i_lane_en(en), .i_p(p), .o_acc(acc_w), .o_valid(vld_w), .o_sat(sat_w),
    .o_approx_bits(ab_w));

  int n_chk = 0, n_fail = 0;
  int m_acc_s [NL];
  int m_acc_w [NL];
  logic [NL-1:0] m_sat;
  logic m_vld;
  int m_k;

  typedef struct {
    logic          cw;
    logic [AW-1:0] ab;
    logic          v;
    logic          clr;
    logic [IW-1:0] p;
    logic [OW-1:0] exp0;
    logic [AW-1:0] expk;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Approximate sum from the rules: OR below bit k, carry from bit k-1, exact add above.
  function automatic int loa(input int a, input int b, input int k);
    int m, lo, cy, hi;
    m  = 1 << k;
    lo = (a | b) % m;
    cy = (k > 0) ? (((a >> (k-1)) & (b >> (k-1))) & 1) : 0;
    hi = ((a / m) + (b / m) + cy) % (65536 / m);
    return hi * m + lo;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      m_acc_s[l] = 0;
      m_acc_w[l] = 0;
    end
    m_sat = '0;
    m_vld = 1'b0;
    m_k   = 0;
  endtask

  task automatic model_step();
    int pe, cs, cw, r;
    bit of;
    if (valid) begin
      for (int l = 0; l < NL; l++) begin
        if (en[l]) begin
          pe = int'(p[l*IW +: IW]);
          if (pe >= 128) pe += 65280;
          cs = clr ? 0 : m_acc_s[l];
          cw = clr ? 0 : m_acc_w[l];
          r  = loa(pe, cs, m_k);
          of = ((pe >> 15) == (cs >> 15)) && ((r >> 15) != (pe >> 15));
          if (of) r = (pe >= 32768) ? 32768 : 32767;
          m_acc_s[l] = r;
          m_sat[l]   = clr ? of : (m_sat[l] | of);
          m_acc_w[l] = loa(pe, cw, m_k);
        end
      end
    end
    m_vld = valid;
    if (cfg_we) m_k = (int'(ab) > MA) ? MA : int'(ab);
  endtask

  task automatic compare_all();
    logic [NL*OW-1:0] es, ew;
    for (int l = 0; l < NL; l++) begin
      es[l*OW +: OW] = m_acc_s[l][OW-1:0];
      ew[l*OW +: OW] = m_acc_w[l][OW-1:0];
    end
    chk("acc_sat", acc_s, es);
    chk("acc_wrap", acc_w, ew);
    chk("sat_flag", sat_s, m_sat);
    chk("sat_flag_wrap", sat_w, '0);
    chk("valid", {vld_s, vld_w}, {m_vld, m_vld});
    chk("k", {ab_s, ab_w}, {m_k[AW-1:0], m_k[AW-1:0]});
  endtask

  task automatic cycle(input logic c_we, input logic [AW-1:0] c_ab, input logic c_v,
                       input logic c_clr, input logic [NL-1:0] c_en, input logic [NL*IW-1:0] c_p);
    cfg_we = c_we; ab = c_ab; valid = c_v; clr = c_clr; en = c_en; p = c_p;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    tbl[0]  = '{1'b0, 3'd0, 1'b1, 1'b1, 8'h05, 16'h0005, 3'd0};
    tbl[1]  = '{1'b0, 3'd0, 1'b1, 1'b0, 8'hFD, 16'h0002, 3'd0};
    tbl[2]  = '{1'b1, 3'd4, 1'b0, 1'b0, 8'h00, 16'h0002, 3'd4};
    tbl[3]  = '{1'b0, 3'd0, 1'b1, 1'b1, 8'h03, 16'h0003, 3'd4};
    tbl[4]  = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h05, 16'h0007, 3'd4};
    tbl[5]  = '{1'b0, 3'd0, 1'b1, 1'b1, 8'h08, 16'h0008, 3'd4};
    tbl[6]  = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h08, 16'h0018, 3'd4};
    tbl[7]  = '{1'b0, 3'd0, 1'b1, 1'b1, 8'h08, 16'h0008, 3'd4};
    tbl[8]  = '{1'b1, 3'd6, 1'b1, 1'b0, 8'h08, 16'h0018, 3'd6};
    tbl[9]  = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h08, 16'h0018, 3'd6};
    tbl[10] = '{1'b1, 3'd7, 1'b0, 1'b0, 8'h00, 16'h0018, 3'd6};
    tbl[11] = '{1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 16'h0018, 3'd0};
    tbl[12] = '{1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 16'h0018, 3'd0};

    rstn = 1'b0; cfg_we = 1'b0; ab = '0; valid = 1'b0; clr = 1'b0; en = '0; p = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_acc", {acc_s, acc_w}, '0);
    chk("reset_ctrl", {vld_s, sat_s, ab_s, vld_w, sat_w, ab_w}, '0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].cw, tbl[i].ab, tbl[i].v, tbl[i].clr, 4'hF, {NL{tbl[i].p}});
      chk($sformatf("tbl%0d_acc0", i), acc_s[OW-1:0], tbl[i].exp0);
      chk($sformatf("tbl%0d_k", i), ab_s, tbl[i].expk);
    end

    // Run up to the positive limit: saturating lane clamps, wrapping lane goes negative.
    cycle(1'b0, '0, 1'b1, 1'b1, 4'hF, {NL{8'h7F}});
    for (int i = 0; i < 400 && !acc_w[OW-1]; i++)
      cycle(1'b0, '0, 1'b1, 1'b0, 4'hF, {NL{8'h7F}});
    chk("wrap_negative", acc_w[OW-1], 1'b1);
    chk("sat_clamp", acc_s[OW-1:0], 16'h7FFF);
    chk("sat_sticky", sat_s, 4'hF);
    cycle(1'b0, '0, 1'b1, 1'b0, 4'hF, {NL{8'h01}});
    chk("sat_hold", {acc_s[OW-1:0], sat_s[0]}, {16'h7FFF, 1'b1});
    cycle(1'b0, '0, 1'b1, 1'b1, 4'hF, {NL{8'h01}});
    chk("sat_clear", {acc_s[OW-1:0], sat_s[0]}, {16'h0001, 1'b0});

    cycle(1'b0, '0, 1'b1, 1'b1, 4'hF, {8'd4, 8'd3, 8'd2, 8'd1});
    cycle(1'b0, '0, 1'b1, 1'b1, 4'b0101, {NL{8'd9}});
    chk("lane_en", acc_s, {16'd4, 16'd9, 16'd2, 16'd9});
    cycle(1'b0, '0, 1'b1, 1'b1, 4'b0000, {NL{8'd7}});
    chk("lanes_off_valid", {vld_s, acc_s}, {1'b1, 16'd4, 16'd9, 16'd2, 16'd9});

    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 9) == 0), AW'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) == 0), NL'($urandom), NL*IW'($urandom));

    // Reset dropped between edges must clear state without waiting for the clock.
    cycle(1'b1, 3'd5, 1'b1, 1'b0, 4'hF, {NL{8'h81}});
    #3;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("async_rst_acc", {acc_s, acc_w}, '0);
    chk("async_rst_ctrl", {vld_s, sat_s, ab_s, vld_w, ab_w}, '0);
    @(negedge clk);
    rstn = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0, 4'hF, {NL{8'h05}});
    chk("post_rst_acc0", acc_s[OW-1:0], 16'h0005);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
